// File: rtl/uart_prog_counter.sv
// Runtime-programmable bit-period counter with a cascaded per-frame wrap counter.
// Optional sticky frame flag is built when UART_PROG_COUNTER_STICKY_EN is defined.
module uart_prog_counter #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_MOD  = 16,
    parameter int NUM_WRAPS    = 10,
    parameter int HOLD_ON_IDLE = 0,
    localparam int WRAP_W      = ($clog2(NUM_WRAPS) < 1) ? 1 : $clog2(NUM_WRAPS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic              clear,
    input  logic              mod_load,
    input  logic [WIDTH-1:0]  mod_value,
`ifdef UART_PROG_COUNTER_STICKY_EN
    input  logic              flag_clr,
    output logic              frame_flag,
`endif
    output logic [WIDTH-1:0]  count,
    output logic [WRAP_W-1:0] wraps,
    output logic              counting_done,
    output logic              half_done,
    output logic              frame_done
);

    localparam logic [WIDTH-1:0]  MOD_RESET = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0]  MOD_ONE   = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(NUM_WRAPS - 1);

    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] mid;
    logic             qual;
    logic             restart;

    // A modulus of 1 gives term = mid = 0, so both strobes fire every qualified cycle.
    always_comb begin
        term          = mod_q - MOD_ONE;
        mid           = term >> 1;
        restart       = clear | mod_load;
        qual          = ena & ~restart & ~reset;
        counting_done = qual & (count == term);
        half_done     = qual & (count == mid);
        frame_done    = counting_done & (wraps == WRAP_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            mod_q <= MOD_RESET;
        end else if (restart) begin
            count <= '0;
            if (mod_load) begin
                mod_q <= (mod_value == '0) ? MOD_ONE : mod_value;
            end
        end else if (ena) begin
            count <= (count == term) ? '0 : count + MOD_ONE;
        end else if (HOLD_ON_IDLE == 0) begin
            count <= '0;
        end
    end

    // The wrap counter only moves on terminal strobes, so idle cycles leave it alone.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            wraps <= '0;
        end else if (counting_done) begin
            wraps <= (wraps == WRAP_LAST) ? '0 : wraps + 1'b1;
        end
    end

`ifdef UART_PROG_COUNTER_STICKY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_flag <= 1'b0;
        end else if (frame_done) begin
            frame_flag <= 1'b1;
        end else if (flag_clr) begin
            frame_flag <= 1'b0;
        end
    end
`endif

endmodule
